// File: rtl/control_muestreo_temp.sv
// Sampling scheduler: paces sensor reads, runs the request/valid handshake with timeout,
// registers accepted readings and the out-of-range persistence count. Optional macro: PROMEDIO_TEMP_EN.
module control_muestreo_temp #(
    parameter int PERIODO   = 100,
    parameter int TIMEOUT   = 16,
    parameter int TEMP_BAJO = 180,
    parameter int TEMP_ALTO = 259
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               habilitar,
    input  logic signed [10:0] temp_sensor,
    input  logic               sensor_valido,
    output logic               solicitud,
    output logic signed [10:0] temp_registrado,
    output logic [2:0]         contador_fuera_rango,
    output logic               muestra_nueva,
    output logic               error_sensor,
    output logic [1:0]         estado_ctrl
);

    typedef enum logic [1:0] {
        ESPERA    = 2'b00,
        SOLICITUD = 2'b01,
        ACTUALIZA = 2'b10,
        ERROR     = 2'b11
    } estado_t;

    localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PER_MAX = PW'(PERIODO - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
    localparam logic signed [10:0] LIM_BAJO = 11'(TEMP_BAJO);
    localparam logic signed [10:0] LIM_ALTO = 11'(TEMP_ALTO);

    estado_t               r_estado;
    estado_t               w_estado_sig;
    logic [PW-1:0]         r_cnt_per;
    logic [PW-1:0]         w_cnt_per_sig;
    logic [TW-1:0]         r_cnt_to;
    logic [TW-1:0]         w_cnt_to_sig;
    logic                  w_capturar;

    logic signed [10:0]    r_captura;
    logic                  r_solicitud;
    logic signed [10:0]    r_temp;
    logic [2:0]            r_contador;
    logic                  r_muestra_nueva;
    logic                  r_error;

    logic signed [10:0]    w_muestra;
    logic                  w_fuera;
    logic [2:0]            w_contador_sig;

    // ------------------------------------------------------------------
    // FSM: state and pacing counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= ESPERA;
            r_cnt_per <= '0;
            r_cnt_to  <= '0;
        end else begin
            r_estado  <= w_estado_sig;
            r_cnt_per <= w_cnt_per_sig;
            r_cnt_to  <= w_cnt_to_sig;
        end
    end

    always_comb begin
        w_estado_sig  = r_estado;
        w_cnt_per_sig = '0;
        w_cnt_to_sig  = '0;
        w_capturar    = 1'b0;
        unique case (r_estado)
            ESPERA: begin
                if (habilitar) begin
                    if (r_cnt_per == PER_MAX) begin
                        w_estado_sig = SOLICITUD;
                    end else begin
                        w_cnt_per_sig = r_cnt_per + 1'b1;
                    end
                end
            end
            SOLICITUD: begin
                // An abort outranks a late reply; a reply outranks the timeout.
                if (!habilitar) begin
                    w_estado_sig = ESPERA;
                end else if (sensor_valido) begin
                    w_capturar   = 1'b1;
                    w_estado_sig = ACTUALIZA;
                end else if (r_cnt_to == TO_MAX) begin
                    w_estado_sig = ERROR;
                end else begin
                    w_cnt_to_sig = r_cnt_to + 1'b1;
                end
            end
            ACTUALIZA: w_estado_sig = ESPERA;
            ERROR:     w_estado_sig = ESPERA;
            default:   w_estado_sig = ESPERA;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample value used for registering and the range test
    // ------------------------------------------------------------------
`ifdef PROMEDIO_TEMP_EN
    logic signed [10:0] r_hist [3];
    logic               r_hist_lleno;
    logic signed [12:0] w_suma;

    function automatic logic signed [12:0] ext13(input logic signed [10:0] v);
        return {{2{v[10]}}, v};
    endfunction

    // The window is the current capture plus the three accepted before it.
    always_comb begin
        if (r_hist_lleno) begin
            w_suma = ext13(r_captura) + ext13(r_hist[0]) + ext13(r_hist[1]) + ext13(r_hist[2]);
        end else begin
            w_suma = ext13(r_captura) <<< 2;
        end
        w_muestra = w_suma[12:2];
    end

    // NOTE: history entries carry no reset; r_hist_lleno gates them, so the first
    // sample after reset overwrites whatever they held.
    always_ff @(posedge clk) begin
        if (!rst && r_estado == ACTUALIZA) begin
            r_hist[0] <= r_captura;
            r_hist[1] <= r_hist_lleno ? r_hist[0] : r_captura;
            r_hist[2] <= r_hist_lleno ? r_hist[1] : r_captura;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_lleno <= 1'b0;
        end else if (r_estado == ACTUALIZA) begin
            r_hist_lleno <= 1'b1;
        end
    end
`else
    always_comb begin
        w_muestra = r_captura;
    end
`endif

    always_comb begin
        w_fuera = (w_muestra < LIM_BAJO) || (w_muestra > LIM_ALTO);
        if (!w_fuera) begin
            w_contador_sig = 3'd0;
        end else if (r_contador == 3'd7) begin
            w_contador_sig = 3'd7;
        end else begin
            w_contador_sig = r_contador + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_captura       <= '0;
            r_solicitud     <= 1'b0;
            r_temp          <= '0;
            r_contador      <= '0;
            r_muestra_nueva <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_solicitud     <= (w_estado_sig == SOLICITUD);
            r_muestra_nueva <= 1'b0;
            if (w_capturar) begin
                r_captura <= temp_sensor;
            end
            if (r_estado == ACTUALIZA) begin
                r_temp          <= w_muestra;
                r_contador      <= w_contador_sig;
                r_error         <= 1'b0;
                r_muestra_nueva <= 1'b1;
            end
            if (w_estado_sig == ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

    assign solicitud            = r_solicitud;
    assign temp_registrado      = r_temp;
    assign contador_fuera_rango = r_contador;
    assign muestra_nueva        = r_muestra_nueva;
    assign error_sensor         = r_error;
    assign estado_ctrl          = r_estado;

endmodule

// File: tb/tb_control_muestreo_temp.sv
// Self-checking bench for control_muestreo_temp: transaction-level model plus per-cycle compare.
module tb_control_muestreo_temp;

    localparam int PERIODO   = 4;
    localparam int TIMEOUT   = 3;
    localparam int TEMP_BAJO = 180;
    localparam int TEMP_ALTO = 259;

    logic               clk = 1'b0;
    logic               rst;
    logic               habilitar;
    logic signed [10:0] temp_sensor;
    logic               sensor_valido;
    logic               solicitud;
    logic signed [10:0] temp_registrado;
    logic [2:0]         contador_fuera_rango;
    logic               muestra_nueva;
    logic               error_sensor;
    logic [1:0]         estado_ctrl;

    control_muestreo_temp #(
        .PERIODO  (PERIODO),
        .TIMEOUT  (TIMEOUT),
        .TEMP_BAJO(TEMP_BAJO),
        .TEMP_ALTO(TEMP_ALTO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .habilitar           (habilitar),
        .temp_sensor         (temp_sensor),
        .sensor_valido       (sensor_valido),
        .solicitud           (solicitud),
        .temp_registrado     (temp_registrado),
        .contador_fuera_rango(contador_fuera_rango),
        .muestra_nueva       (muestra_nueva),
        .error_sensor        (error_sensor),
        .estado_ctrl         (estado_ctrl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: what the registered outputs must show right now.
    int  exp_temp  = 0;
    int  exp_cnt   = 0;
    int  exp_err   = 0;
    int  exp_pulse = 0;
    int  hist[$];
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelo_reset();
        exp_temp  = 0;
        exp_cnt   = 0;
        exp_err   = 0;
        exp_pulse = 0;
        hist.delete();
    endtask

    task automatic aceptar(input int v);
        int m;
`ifdef PROMEDIO_TEMP_EN
        int s;
        if (hist.size() == 0) begin
            for (int i = 0; i < 4; i++) hist.push_back(v);
        end else begin
            void'(hist.pop_front());
            hist.push_back(v);
        end
        s = 0;
        foreach (hist[i]) s += hist[i];
        m = (s >= 0) ? s / 4 : -((-s + 3) / 4);
`else
        m = v;
`endif
        exp_temp = m;
        if (m < TEMP_BAJO || m > TEMP_ALTO) exp_cnt = (exp_cnt >= 7) ? 7 : exp_cnt + 1;
        else exp_cnt = 0;
        exp_err   = 0;
        exp_pulse = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("temp_registrado", temp_registrado, exp_temp);
            check("contador_fuera_rango", contador_fuera_rango, exp_cnt);
            check("error_sensor", error_sensor, exp_err);
            check("muestra_nueva", muestra_nueva, exp_pulse);
        end
    end

    // Returns at posedge+1 of the first SOLICITUD cycle; n = cycles waited.
    task automatic esperar_solicitud(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (solicitud === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("espera_solicitud", solicitud, 1);
    endtask

    task automatic muestra(input int v, input int retardo, output int ciclos);
        bit ok;
        esperar_solicitud(ok, ciclos);
        if (!ok) return;
        for (int i = 0; i < retardo; i++) begin
            check("estado_solicitud", estado_ctrl, 1);
            check("solicitud_alta", solicitud, 1);
            tick();
        end
        check("estado_solicitud", estado_ctrl, 1);
        check("solicitud_alta", solicitud, 1);
        sensor_valido = 1'b1;
        temp_sensor   = v[10:0];
        tick();
        sensor_valido = 1'b0;
        temp_sensor   = '0;
        check("estado_actualiza", estado_ctrl, 2);
        check("solicitud_baja", solicitud, 0);
        tick();
        aceptar(v);
        check("estado_espera", estado_ctrl, 0);
        tick();
        exp_pulse = 0;
    endtask

    task automatic sin_respuesta();
        bit ok;
        int n;
        esperar_solicitud(ok, n);
        if (!ok) return;
        for (int i = 0; i < TIMEOUT; i++) begin
            check("estado_solicitud_to", estado_ctrl, 1);
            tick();
        end
        exp_err = 1;
        check("estado_error", estado_ctrl, 3);
        check("solicitud_error", solicitud, 0);
        tick();
        check("estado_tras_error", estado_ctrl, 0);
    endtask

    task automatic aplicar_reset();
        rst           = 1'b1;
        sensor_valido = 1'b0;
        tick();
        modelo_reset();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        int t2 [10];
        int c2 [10];
        int t3 [3];
        int c3 [3];
        t2 = '{150, 150, 150, 150, 150, 150, 150, 150, 150, 220};
        c2 = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 0};
        t3 = '{150, 300, 200};
        c3 = '{1, 2, 0};

        rst           = 1'b1;
        habilitar     = 1'b0;
        sensor_valido = 1'b0;
        temp_sensor   = '0;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        check("reset_estado", estado_ctrl, 0);
        check("reset_solicitud", solicitud, 0);
        check("reset_temp", temp_registrado, 0);
        check("reset_contador", contador_fuera_rango, 0);
        check("reset_error", error_sensor, 0);
        check("reset_pulso", muestra_nueva, 0);

        // 1: first sample, reply on the second request cycle
        habilitar = 1'b1;
        muestra(220, 1, n);
        check("periodo_primera_solicitud", n, PERIODO);
`ifndef PROMEDIO_TEMP_EN
        check("t1_temp", temp_registrado, 220);
        check("t1_contador", contador_fuera_rango, 0);
`endif

        // 2: persistent low readings saturate, in-range clears
        for (int i = 0; i < 10; i++) begin
            muestra(t2[i], 0, n);
`ifndef PROMEDIO_TEMP_EN
            check("t2_temp", temp_registrado, t2[i]);
            check("t2_contador", contador_fuera_rango, c2[i]);
`endif
        end

        // 3: switching from low to high keeps counting
        for (int i = 0; i < 3; i++) begin
            muestra(t3[i], 1, n);
`ifndef PROMEDIO_TEMP_EN
            check("t3_contador", contador_fuera_rango, c3[i]);
`endif
        end

        // 4: timeout, then recovery
        sin_respuesta();
        check("t4_error_set", error_sensor, 1);
        muestra(200, 0, n);
        check("t4_error_clear", error_sensor, 0);
`ifndef PROMEDIO_TEMP_EN
        check("t4_temp", temp_registrado, 200);
`endif

        // 5: reply on the last allowed cycle wins over the timeout
        muestra(230, TIMEOUT - 1, n);
        check("t5_sin_error", error_sensor, 0);

        // valid outside SOLICITUD is ignored
        sensor_valido = 1'b1;
        temp_sensor   = -11'sd500;
        tick();
        tick();
        check("t5_valido_ignorado", estado_ctrl, 0);
        sensor_valido = 1'b0;
        temp_sensor   = '0;

        // habilitar dropped mid-request aborts without update
        esperar_solicitud(ok, n);
        habilitar = 1'b0;
        tick();
        check("t5_abort_estado", estado_ctrl, 0);
        check("t5_abort_solicitud", solicitud, 0);
        tick();
        habilitar = 1'b1;

        // make outputs non-zero, then reset mid-request
        muestra(300, 0, n);
        sin_respuesta();
        esperar_solicitud(ok, n);
        tick();
        rst = 1'b1;
        tick();
        modelo_reset();
        check("t5_rst_estado", estado_ctrl, 0);
        check("t5_rst_solicitud", solicitud, 0);
        check("t5_rst_temp", temp_registrado, 0);
        check("t5_rst_contador", contador_fuera_rango, 0);
        check("t5_rst_error", error_sensor, 0);
        rst = 1'b0;

`ifdef PROMEDIO_TEMP_EN
        // 6: moving average
        muestra(200, 0, n);
        check("t6_avg0", temp_registrado, 200);
        muestra(200, 0, n);
        check("t6_avg1", temp_registrado, 200);
        muestra(200, 0, n);
        check("t6_avg2", temp_registrado, 200);
        muestra(240, 0, n);
        check("t6_avg3", temp_registrado, 210);
        aplicar_reset();
        muestra(-8, 0, n);
        check("t6_neg0", temp_registrado, -8);
        muestra(-7, 0, n);
        check("t6_neg1", temp_registrado, -8);
`else
        muestra(-8, 0, n);
        check("t6_neg_raw", temp_registrado, -8);
        check("t6_neg_contador", contador_fuera_rango, 1);
`endif

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
